ram_1w1r_be: RTL
================

// Module: ram_1w1r_be
// PURPOSE
//   Simple dual-port RAM: one write port, one independent read port, single clock.
//   Successor to the single-port RAM, adding per-byte write enables, an optional output register and a read-valid strobe.
//   Also adds a selectable read-during-write mode and a post-reset clear sequencer that zero-fills the array.
//   Used as the generic storage for FIFOs, line buffers and register files.
// PARAMETERS
//   DATA_W     16              word width in bits; must be a multiple of BYTE_W
//   DEPTH      16              number of words; need not be a power of 2
//   ADDR_W     $clog2(DEPTH)   address width
//   BYTE_W     8               bits per write-enable lane; NBE = DATA_W/BYTE_W
//   OUT_REG    1'b0            0: read latency 1; 1: extra output register, latency 2
//   RDW_MODE   1'b0            same-address read during write: 0 = old data, 1 = new data
//   INIT_CLEAR 1'b1            1: zero-fill all words after every reset release
// PORTS
//   clk        in   1       clock, all logic on posedge
//   rst_n      in   1       reset, asynchronous, active-low
//   init_busy  out  1       clear sequencer running; port operations ignored
//   we         in   1       write request
//   w_addr     in   ADDR_W  write address
//   w_data     in   DATA_W  write data
//   w_be       in   NBE     byte enables; bit i covers w_data[i*BYTE_W +: BYTE_W]
//   re         in   1       read request
//   r_addr     in   ADDR_W  read address
//   r_data     out  DATA_W  read data; holds its value between reads
//   r_valid    out  1       1-cycle strobe: r_data carries the result of one read
// BEHAVIOUR
//   Reset (rst_n=0, async)
//   - r_data=0, r_valid=0, all pipeline registers cleared.
//   - init_busy=INIT_CLEAR; the clear counter returns to 0.
//   - Memory contents are not reset directly.
//   Clear FSM: CLEAR -> DONE.
//   - CLEAR is entered on reset release when INIT_CLEAR=1.
//   - CLEAR writes 0 to word cnt, cnt 0..DEPTH-1, one word per cycle; init_busy=1 for exactly DEPTH cycles after release.
//   - DONE is terminal until the next reset; init_busy=0 in DONE.
//   - Reset asserted during CLEAR aborts the fill; the next release restarts it at word 0.
//   - INIT_CLEAR=0: FSM stays in DONE, init_busy is constant 0, power-up contents undefined.
//   Write: when we=1 and init_busy=0, at the posedge, lanes with w_be[i]=1 are updated; other lanes keep their contents. we with w_be=0 is a no-op.
//   Read: when re=1 and init_busy=0, r_addr is sampled at posedge T.
//   - OUT_REG=0: r_data and r_valid update after posedge T.
//   - OUT_REG=1: r_data and r_valid update after posedge T+1.
//   - Full throughput: one read per cycle, results in issue order. With OUT_REG=1, r_data holds its value whenever r_valid=0.
//   Simultaneous write and read to the same address:
//   - RDW_MODE=0: read returns the pre-write word.
//   - RDW_MODE=1: read returns the merged word (enabled lanes from w_data, other lanes old); implemented as a bypass.
//   - Different addresses: fully independent.
//   Address range: address >= DEPTH is ignored for writes; a read at such an address returns 0 with r_valid=1.
//   While init_busy=1: we and re are ignored and r_valid=0.
//   Reset mid-operation: in-flight reads are dropped with no r_valid; writes not yet clocked are lost.
//   Elaboration error if DATA_W % BYTE_W != 0 or DEPTH < 2.
// TESTING (DATA_W=16, BYTE_W=8, DEPTH=16 unless noted)
//   1 Release rst_n -> init_busy=1 for exactly 16 cycles; then read addrs 0..15 -> every r_data=16'h0000.
//   2 Write 16'hABCD @3 be=11, then 16'h1200 @3 be=10; read @3 -> 16'h12CD. r_valid 1 cycle after re (OUT_REG=0), 2 cycles after (OUT_REG=1).
//   3 mem[5]=16'h1111; same cycle write 16'h2222 @5 be=11 and read @5 -> 16'h1111 (RDW_MODE=0), 16'h2222 (RDW_MODE=1); with be=01 and RDW_MODE=1 -> 16'h1122.
//   4 Fill mem[i]=i*16'h0101; re=1 with addrs 0..15 on consecutive cycles -> 16 consecutive r_valid, data in order, both OUT_REG values.
//   5 Assert rst_n=0 at clear cycle 8 -> r_valid, r_data go 0 immediately; after release init_busy=1 for 16 cycles, all words read 0.
//   6 During init_busy: we=1 @2 data 16'hFFFF -> ignored, later reads 0. DEPTH=12: write @13 ignored; read @13 -> 0 with r_valid=1.

Source files
------------

// File: rtl/ram_1w1r_be.sv
// ram_1w1r_be: single-clock 1W1R RAM with byte enables, optional output register, RDW bypass and post-reset zero fill
module ram_1w1r_be #(
  parameter int DATA_W     = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int BYTE_W     = 8,
  parameter bit OUT_REG    = 1'b0,
  parameter bit RDW_MODE   = 1'b0,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     init_busy,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic [DATA_W-1:0]        w_data,
  input  logic [DATA_W/BYTE_W-1:0] w_be,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        r_addr,
  output logic [DATA_W-1:0]        r_data,
  output logic                     r_valid
);
  localparam int NBE = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic {CLEAR, DONE} state_t;
  state_t state, state_nx;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] r_word, d1, d2;
  logic w_ok, r_ok, r_hit, r_acc, v1, v2;
  if (DATA_W % BYTE_W != 0 || DEPTH < 2) begin : g_bad_params
    $error("ram_1w1r_be: DATA_W must be a multiple of BYTE_W and DEPTH >= 2");
  end
  always_comb begin
    state_nx = state;
    init_busy = 1'b0;
    if (state == CLEAR) begin
      init_busy = 1'b1;
      state_nx = (cnt == LAST) ? DONE : CLEAR;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT_CLEAR ? CLEAR : DONE;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (init_busy) cnt <= cnt + 1'b1;
    end
  assign w_ok = we && !init_busy && ({1'b0, w_addr} < DEPTH_L);
  assign r_ok = {1'b0, r_addr} < DEPTH_L;
  assign r_hit = RDW_MODE && w_ok && (w_addr == r_addr);
  assign r_acc = re && !init_busy;
  // new-data mode merges the enabled write lanes over the stored word
  always_comb begin
    r_word = r_ok ? mem[r_addr] : '0;
    for (int i = 0; i < NBE; i++)
      if (r_hit && w_be[i]) r_word[i*BYTE_W +: BYTE_W] = w_data[i*BYTE_W +: BYTE_W];
  end
  always_ff @(posedge clk)
    if (init_busy) mem[cnt] <= '0;
    else if (w_ok)
      for (int i = 0; i < NBE; i++)
        if (w_be[i]) mem[w_addr][i*BYTE_W +: BYTE_W] <= w_data[i*BYTE_W +: BYTE_W];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      d1 <= '0;
      v2 <= 1'b0;
      d2 <= '0;
    end else begin
      v1 <= r_acc;
      if (r_acc) d1 <= r_word;
      v2 <= v1;
      if (v1) d2 <= d1;
    end
  assign r_valid = OUT_REG ? v2 : v1;
  assign r_data = OUT_REG ? d2 : d1;
endmodule
